// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and clear-sequencer state encoding for the
//               multi-ported register file.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default geometry of the general-purpose register file
    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 5;

    // Clear-sequencer states
    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One combinational read port: zero-register check, same-cycle
//               write bypass (highest write port wins) and busy masking.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     ready,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        arr_data,
    input  logic                     arr_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_busy
);

    // Read mux: array, overridden by bypass (later ports override earlier),
    // overridden by the hard-wired zero register; all zero while clearing.
    always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (ready) begin
            rd_data = arr_data;
            rd_busy = arr_busy;
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
                        rd_data = wr_data[j*DATA_W +: DATA_W];
                        rd_busy = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb
// Description : Multi-ported register file with write-to-read bypass, a
//               per-register busy scoreboard and a post-reset clear sequencer
//               that zeroes the array instead of resetting it.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     init_done
);

    localparam int c_DEPTH = 2**ADDR_W;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;
    logic              w_ready;
    logic [NUM_WR-1:0] w_wr_en;

    assign w_ready   = (r_state == c_ST_READY);
    assign init_done = w_ready;
    // Writes are only honoured once the array has been cleared
    assign w_wr_en   = wr_en & {NUM_WR{w_ready}};

    // State register for the clear sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave CLEAR after the last entry has been zeroed
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == c_ST_CLEAR) && (r_clr_cnt == {ADDR_W{1'b1}})) begin
            w_state_nxt = c_ST_READY;
        end
    end

    // Clear pointer walks every entry once per reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_cnt <= '0;
        end else if (r_state == c_ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // Array: zeroed entry by entry while clearing, otherwise written by the
    // ports in ascending order so the highest-index port wins a collision
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == c_ST_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wr_en[j] &&
                        !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == '0))) begin
                        r_mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Scoreboard: writeback clears, issue sets, and a same-cycle issue wins
    // because it names a newer producer still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else if (w_ready) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wr_en[j]) begin
                    r_busy[wr_addr[j*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            if (iss_en) begin
                r_busy[iss_addr] <= 1'b1;
            end
            if (ZERO_REG != 0) begin
                r_busy[0] <= 1'b0;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
            logic [ADDR_W-1:0] w_rd_addr;
            assign w_rd_addr = rd_addr[k*ADDR_W +: ADDR_W];

            rf_read_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .NUM_WR   (NUM_WR),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd_port (
                .ready    (w_ready),
                .rd_addr  (w_rd_addr),
                .arr_data (r_mem[w_rd_addr]),
                .arr_busy (r_busy[w_rd_addr]),
                .wr_en    (w_wr_en),
                .wr_addr  (wr_addr),
                .wr_data  (wr_data),
                .rd_data  (rd_data[k*DATA_W +: DATA_W]),
                .rd_busy  (rd_busy[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp_sb
// Description : Self-checking bench for regfile_mp_sb against a behavioural
//               register-file model, with directed scenarios and random ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        init_done;

    logic [4:0]  ra [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic        we [2];

    assign rd_addr = {ra[1], ra[0]};
    assign wr_addr = {wa[1], wa[0]};
    assign wr_data = {wd[1], wd[0]};
    assign wr_en   = {we[1], we[0]};

    regfile_mp_sb dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_ready = 0;
    bit          m_known = 0;
    int          m_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit nb [32];
        if (reset) begin
            m_known = 1;
            m_ready = 0;
            m_cnt   = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else if (m_known) begin
            if (!m_ready) begin
                m_mem[m_cnt] = 32'h0;
                m_cnt++;
                if (m_cnt == 32) m_ready = 1;
            end else begin
                nb = m_busy;
                for (int j = 0; j < 2; j++) begin
                    if (we[j]) begin
                        if (wa[j] != 0) m_mem[wa[j]] = wd[j];
                        nb[wa[j]] = 0;
                    end
                end
                if (iss_en) nb[iss_addr] = 1;
                nb[0] = 0;
                m_busy = nb;
            end
        end
    endtask

    task automatic exp_rd(input logic [4:0] a, output logic [31:0] d, output logic b);
        d = 32'h0;
        b = 1'b0;
        if (m_ready && a != 0) begin
            d = m_mem[a];
            b = m_busy[a];
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wa[j] == a) begin
                    d = wd[j];
                    b = 1'b0;
                end
            end
        end
    endtask

    // Wait for the sampling edge and compare every output to the model
    task automatic settle();
        logic [31:0] d;
        logic        b;
        @(negedge clk);
        if (m_known) begin
            chk("init_done", {31'b0, init_done}, {31'b0, m_ready});
            for (int k = 0; k < 2; k++) begin
                exp_rd(ra[k], d, b);
                chk($sformatf("rd_data%0d", k), rd_data[k*32 +: 32], d);
                chk($sformatf("rd_busy%0d", k), {31'b0, rd_busy[k]}, {31'b0, b});
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        we[0] = 0; we[1] = 0; iss_en = 0;
    endtask

    task automatic count_init(input string name);
        int low = 0;
        settle();
        while (init_done !== 1'b1 && low < 100) begin
            low++;
            adv();
            settle();
        end
        chk(name, low, 32);
        adv();
    endtask

    function automatic logic [4:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        reset = 1; iss_en = 0; iss_addr = 0;
        for (int j = 0; j < 2; j++) begin
            ra[j] = 0; wa[j] = 0; wd[j] = 0; we[j] = 0;
        end

        // 1. clear sequence after reset
        settle(); adv();
        settle(); adv();
        reset = 0;
        count_init("init_cycles");
        ra[0] = 5'd1; ra[1] = 5'd31;
        settle();
        chk("clr_r1", rd_data[31:0], 32'h0);
        chk("clr_r31", rd_data[63:32], 32'h0);
        adv();

        // 2. two ports writing r5 in one cycle
        we[0] = 1; wa[0] = 5'd5; wd[0] = 32'h11;
        we[1] = 1; wa[1] = 5'd5; wd[1] = 32'h22;
        ra[0] = 5'd5;
        settle();
        chk("coll_bypass", rd_data[31:0], 32'h22);
        adv(); idle_inputs();
        settle();
        chk("coll_array", rd_data[31:0], 32'h22);
        adv();

        // 3. writes to r0 are dropped
        we[0] = 1; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF;
        we[1] = 1; wa[1] = 5'd0; wd[1] = 32'hFFFF_FFFF;
        ra[0] = 5'd0;
        settle();
        chk("r0_same", rd_data[31:0], 32'h0);
        chk("r0_busy", {31'b0, rd_busy[0]}, 32'h0);
        adv(); idle_inputs();
        settle();
        chk("r0_after", rd_data[31:0], 32'h0);
        adv();

        // 4. issue r7, then writeback r7
        iss_en = 1; iss_addr = 5'd7; ra[1] = 5'd7;
        settle();
        chk("iss_nofwd", {31'b0, rd_busy[1]}, 32'h0);
        adv(); idle_inputs();
        settle();
        chk("iss_busy", {31'b0, rd_busy[1]}, 32'h1);
        adv();
        we[0] = 1; wa[0] = 5'd7; wd[0] = 32'hAB;
        settle();
        chk("wb_busy", {31'b0, rd_busy[1]}, 32'h0);
        chk("wb_data", rd_data[63:32], 32'hAB);
        adv(); idle_inputs();
        settle();
        chk("wb_busy_next", {31'b0, rd_busy[1]}, 32'h0);
        adv();

        // 5. issue and write r9 together: set wins
        iss_en = 1; iss_addr = 5'd9;
        we[0] = 1; wa[0] = 5'd9; wd[0] = 32'h99; ra[0] = 5'd9;
        settle();
        adv(); idle_inputs();
        settle();
        chk("setwin_busy", {31'b0, rd_busy[0]}, 32'h1);
        chk("setwin_data", rd_data[31:0], 32'h99);
        adv();

        // 6. reset mid-clear, and re-clear of written data
        we[0] = 1; wa[0] = 5'd3; wd[0] = 32'h5;
        settle(); adv(); idle_inputs();
        reset = 1; settle(); adv();
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            settle(); adv();
        end
        reset = 1; settle(); adv();
        reset = 0;
        count_init("reinit_cycles");
        ra[0] = 5'd3;
        settle();
        chk("r3_cleared", rd_data[31:0], 32'h0);
        adv();

        // Random traffic, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 599) == 0);
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = rand_addr();
            for (int j = 0; j < 2; j++) begin
                we[j] = 1'($urandom_range(0, 1));
                wa[j] = rand_addr();
                wd[j] = $urandom;
            end
            for (int k = 0; k < 2; k++) begin
                ra[k] = ($urandom_range(0, 2) == 0) ? wa[$urandom_range(0, 1)] : rand_addr();
            end
            settle();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
